// File: rtl/fifo_read_port_adapter_pkg.sv
// Shared definitions for the async-FIFO read-port adapter: default word width
// and the skid-buffer occupancy encoding.
package fifo_read_port_adapter_pkg;

  localparam int WORD_DEFAULT = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_read_port_adapter_skid.sv
// Two-entry head/tail skid buffer with EMPTY/ONE/TWO occupancy FSM.
// The head always holds the oldest word; flush empties the buffer.
module fifo_read_port_adapter_skid
  import fifo_read_port_adapter_pkg::*;
#(
  parameter int WORD = WORD_DEFAULT
) (
  input  logic            rclk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [WORD-1:0] din,
  output occ_t            occ,
  output logic [WORD-1:0] head
);

  logic [WORD-1:0] tail;

  always_ff @(posedge rclk) begin
    if (rst) begin
      occ  <= OCC_EMPTY;
      head <= '0;
    end else if (flush) begin
      occ <= OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head <= din;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail <= din;
            occ  <= OCC_TWO;
          end else if (pop) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Head drains from tail; a simultaneous arrival refills the tail.
          if (push && pop) begin
            head <= tail;
            tail <= din;
          end else if (pop) begin
            head <= tail;
            occ  <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  // The credit rule upstream must never let a word arrive into a full buffer.
  always_ff @(posedge rclk) begin
    if (!rst) begin
      assert (!(push && !pop && occ == OCC_TWO));
    end
  end

endmodule

// File: rtl/fifo_read_port_adapter.sv
// Read-side consumer for the async FIFO: issues ren with credit control, absorbs
// the 1-cycle read latency in a skid buffer, streams valid/ready, counts words.
// Optional FIFO_RD_CHECKSUM_EN adds rd_checksum (XOR of delivered words).
module fifo_read_port_adapter
  import fifo_read_port_adapter_pkg::*;
#(
  parameter int WORD  = WORD_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rst,
  output logic             fifo_ren,
  input  logic             fifo_empty,
  input  logic [WORD-1:0]  fifo_rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
`ifdef FIFO_RD_CHECKSUM_EN
  output logic [WORD-1:0]  rd_checksum,
`endif
  output logic [CNT_W-1:0] word_cnt
);

  occ_t occ;
  logic inflight;
  logic pop;
  logic push;
  logic [2:0] committed;

  assign out_valid = (occ != OCC_EMPTY);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Slots still owed after this cycle's pop; out_ready feeds ren so a full
  // buffer being drained can keep reading at 1 word/cycle.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_ren  = !rst && !fifo_empty && !flush && (committed < 3'd2);

  fifo_read_port_adapter_skid #(
    .WORD(WORD)
  ) u_skid (
    .rclk  (rclk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_rdata),
    .occ   (occ),
    .head  (out_data)
  );

  // A word requested during flush is never issued, and one already in flight
  // lands on the flush edge where the buffer is being cleared.
  always_ff @(posedge rclk) begin
    if (rst) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_ren;
      if (pop) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

`ifdef FIFO_RD_CHECKSUM_EN
  always_ff @(posedge rclk) begin
    if (rst || flush) begin
      rd_checksum <= '0;
    end else if (pop) begin
      rd_checksum <= rd_checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_port_adapter.sv
// Randomized bench for fifo_read_port_adapter: a queue-based FIFO model feeds the
// DUT, and a queue-level reference of words owed downstream checks every cycle.
module tb_fifo_read_port_adapter;

  localparam int WORD  = 8;
  localparam int CNT_W = 16;

  logic             rclk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_ren;
  logic             fifo_empty = 1'b1;
  logic [WORD-1:0]  fifo_rdata = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WORD-1:0]  out_data;
  logic [CNT_W-1:0] word_cnt;
`ifdef FIFO_RD_CHECKSUM_EN
  logic [WORD-1:0]  rd_checksum;
`endif

  always #5 rclk = ~rclk;

  fifo_read_port_adapter #(
    .WORD  (WORD),
    .CNT_W (CNT_W)
  ) dut (
    .rclk        (rclk),
    .rst         (rst),
    .fifo_ren    (fifo_ren),
    .fifo_empty  (fifo_empty),
    .fifo_rdata  (fifo_rdata),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef FIFO_RD_CHECKSUM_EN
    .rd_checksum (rd_checksum),
`endif
    .word_cnt    (word_cnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [WORD-1:0] fifo_q[$];    // words still inside the upstream FIFO
  logic [WORD-1:0] issued_q[$];  // words the FIFO has driven onto fifo_rdata

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: words owed downstream, in order, plus whether one is in flight.
  logic [WORD-1:0] buf_q[$];
  bit              infl      = 1'b0;
  bit              started   = 1'b0;
  bit              data_zero = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [WORD-1:0]  m_cks = '0;

  always @(negedge rclk) begin
    int   owed;
    bit   pop_e;
    bit   exp_ren;
    logic [WORD-1:0] w;
    pop_e   = (buf_q.size() > 0) && out_ready;
    owed    = buf_q.size() + (infl ? 1 : 0) - (pop_e ? 1 : 0);
    exp_ren = !rst && !fifo_empty && !flush && (owed < 2);
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(buf_q.size() > 0));
      chk("fifo_ren", 32'(fifo_ren), 32'(exp_ren));
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      if (buf_q.size() > 0) chk("out_data", 32'(out_data), 32'(buf_q[0]));
      else if (data_zero) chk("out_data_reset", 32'(out_data), 32'h0);
`ifdef FIFO_RD_CHECKSUM_EN
      chk("rd_checksum", 32'(rd_checksum), 32'(m_cks));
`endif
    end
    if (rst) begin
      if (infl && issued_q.size() > 0) void'(issued_q.pop_front());
      buf_q.delete();
      infl      = 1'b0;
      m_cnt     = '0;
      m_cks     = '0;
      data_zero = 1'b1;
      started   = 1'b1;
    end else if (started) begin
      if (pop_e) begin
        w = buf_q.pop_front();
        m_cnt = m_cnt + 1'b1;
        m_cks = m_cks ^ w;
      end
      if (infl) begin
        if (issued_q.size() == 0) begin
          chk("fifo_read_served", 32'h0, 32'h1);
        end else begin
          w = issued_q.pop_front();
          if (!flush) begin
            buf_q.push_back(w);
            data_zero = 1'b0;
          end
        end
      end
      if (flush) begin
        buf_q.delete();
        m_cks = '0;
      end
      infl = exp_ren;
    end
  end

  // One clock of stimulus: serve a read the DUT issued, then drive new inputs.
  task automatic cycle(input bit r, input int p_ready, input int p_flush,
                       input int p_add, input bit keep_full);
    bit ren_s;
    @(negedge rclk);
    ren_s = fifo_ren;
    @(posedge rclk);
    #1;
    if (ren_s && !rst && fifo_q.size() > 0) begin
      fifo_rdata = fifo_q.pop_front();
      issued_q.push_back(fifo_rdata);
    end
    if (keep_full) begin
      while (fifo_q.size() < 4) fifo_q.push_back(WORD'($urandom));
    end else if ($urandom_range(99) < p_add) begin
      fifo_q.push_back(WORD'($urandom));
    end
    fifo_empty = (fifo_q.size() == 0);
    out_ready  = ($urandom_range(99) < p_ready);
    flush      = ($urandom_range(99) < p_flush);
    rst        = r;
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    // Steady stream with a free-running sink
    for (int i = 0; i < 200; i++) cycle(0, 100, 0, 0, 1);
    // Heavy backpressure, then release
    for (int i = 0; i < 150; i++) cycle(0, 20, 0, 0, 1);
    for (int i = 0; i < 30; i++) cycle(0, 100, 0, 0, 0);
    // Sparse FIFO: single words arriving near the empty boundary
    for (int i = 0; i < 200; i++) cycle(0, 70, 0, 15, 0);
    // Flushes mixed with random ready and fill rate
    for (int i = 0; i < 400; i++) cycle(0, 50, 6, 60, 0);
    // Reset mid-transfer
    cycle(0, 100, 0, 0, 1);
    cycle(1, 100, 0, 0, 1);
    cycle(1, 100, 0, 0, 1);
    fifo_q.delete();
    fifo_empty = 1'b1;
    for (int i = 0; i < 400; i++) cycle(0, 60, 3, 50, 0);
    // Drain
    for (int i = 0; i < 40; i++) cycle(0, 100, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
